sa_pe_sequencer: RTL and testbench

// Job sequencer for one output-stationary sa_processing_element (PE).
// Per job: clears the PE accumulator, streams K operand pairs (valid/ready),

---
 rtl/sa_pe_sequencer_if.sv | 53 +++++
 rtl/sa_pe_sequencer.sv | 162 ++++++++++++++++
 tb/tb_sa_pe_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/sa_pe_sequencer_if.sv
// Handshake and PE-side bundle for sa_pe_sequencer.
// master: job/operand/result environment (fetch FIFOs, result sink, PE o_c).
// slave : the sequencer itself.
// Optional perf counter signals exist only when SA_PE_SEQ_PERF_CNT_EN is defined.
interface sa_pe_sequencer_if #(
  parameter int IA_W = 16,
  parameter int IB_W = 16,
  parameter int OC_W = 32,
  parameter int K_W  = 16
);
  // job control
  logic            i_start;
  logic [K_W-1:0]  i_k_len;
  logic            o_busy;
  logic            o_done;
  // operand stream
  logic            i_op_valid;
  logic            o_op_ready;
  logic [IA_W-1:0] i_op_a;
  logic [IB_W-1:0] i_op_b;
  // PE connection
  logic [IA_W-1:0] o_pe_a;
  logic [IB_W-1:0] o_pe_b;
  logic            o_pe_reg_clear;
  logic            o_pe_pipeline_en;
  logic [OC_W-1:0] i_pe_c;
  // result stream
  logic            o_res_valid;
  logic            i_res_ready;
  logic [OC_W-1:0] o_res_data;
`ifdef SA_PE_SEQ_PERF_CNT_EN
  logic [31:0]     o_busy_cycles;
  logic [31:0]     o_stall_cycles;
`endif

  modport master (
    output i_start, i_k_len, i_op_valid, i_op_a, i_op_b, i_pe_c, i_res_ready,
`ifdef SA_PE_SEQ_PERF_CNT_EN
    input  o_busy_cycles, o_stall_cycles,
`endif
    input  o_busy, o_done, o_op_ready, o_pe_a, o_pe_b, o_pe_reg_clear,
           o_pe_pipeline_en, o_res_valid, o_res_data
  );

  modport slave (
    input  i_start, i_k_len, i_op_valid, i_op_a, i_op_b, i_pe_c, i_res_ready,
`ifdef SA_PE_SEQ_PERF_CNT_EN
    output o_busy_cycles, o_stall_cycles,
`endif
    output o_busy, o_done, o_op_ready, o_pe_a, o_pe_b, o_pe_reg_clear,
           o_pe_pipeline_en, o_res_valid, o_res_data
  );
endinterface

// File: rtl/sa_pe_sequencer.sv
// Job sequencer for one output-stationary processing element.
// Per job: clear the PE accumulator, stream K operand pairs, flush the PE
// MAC pipeline for PE_LAT cycles, then hand out the accumulated result.
// Define SA_PE_SEQ_PERF_CNT_EN to add busy/stall cycle counters.
module sa_pe_sequencer #(
  parameter int IA_W   = 16,
  parameter int IB_W   = 16,
  parameter int OC_W   = 32,
  parameter int K_W    = 16,
  parameter int PE_LAT = 4
) (
  input logic               i_clk,
  input logic               i_rst,
  sa_pe_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    FLUSH = 3'd3,
    DRAIN = 3'd4
  } state_t;

  localparam int FL_W = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
  localparam logic [FL_W-1:0] FLUSH_LAST = FL_W'(PE_LAT - 1);

  state_t            state_reg;
  logic [K_W-1:0]    k_reg;
  logic [K_W-1:0]    cnt_reg;
  logic [FL_W-1:0]   flush_cnt_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              op_ready_reg;
  logic              clear_reg;
  logic              force_en_reg;   // PE enable independent of operands (CLEAR/FLUSH)
  logic              res_valid_reg;
  logic [OC_W-1:0]   res_data_reg;
  logic              op_fire;

  // An operand pair moves only on a real handshake; otherwise the PE is
  // frozen so no zero bubble enters the accumulation.
  assign op_fire = op_ready_reg & bus.i_op_valid;

  // Sequencer FSM with registered control outputs decoded from the next state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg     <= IDLE;
      k_reg         <= '0;
      cnt_reg       <= '0;
      flush_cnt_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      op_ready_reg  <= 1'b0;
      clear_reg     <= 1'b0;
      force_en_reg  <= 1'b0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.i_start) begin
            k_reg        <= bus.i_k_len;
            cnt_reg      <= '0;
            busy_reg     <= 1'b1;
            clear_reg    <= 1'b1;
            force_en_reg <= 1'b1;
            state_reg    <= CLEAR;
          end
        end
        CLEAR: begin
          clear_reg     <= 1'b0;
          flush_cnt_reg <= '0;
          if (k_reg == '0) begin
            force_en_reg <= 1'b1;
            state_reg    <= FLUSH;
          end else begin
            force_en_reg <= 1'b0;
            op_ready_reg <= 1'b1;
            state_reg    <= FEED;
          end
        end
        FEED: begin
          if (op_fire) begin
            cnt_reg <= cnt_reg + K_W'(1);
            // k_reg is non-zero here, so k_reg-1 cannot underflow
            if (cnt_reg == k_reg - K_W'(1)) begin
              op_ready_reg  <= 1'b0;
              force_en_reg  <= 1'b1;
              flush_cnt_reg <= '0;
              state_reg     <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt_reg == FLUSH_LAST) begin
            force_en_reg <= 1'b0;
            state_reg    <= DRAIN;
          end else begin
            flush_cnt_reg <= flush_cnt_reg + FL_W'(1);
          end
        end
        DRAIN: begin
          // First DRAIN cycle captures the settled accumulator; afterwards the
          // result is held until the sink takes it.
          if (!res_valid_reg) begin
            res_data_reg  <= bus.i_pe_c;
            res_valid_reg <= 1'b1;
          end else if (bus.i_res_ready) begin
            res_valid_reg <= 1'b0;
            done_reg      <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg    <= IDLE;
          busy_reg     <= 1'b0;
          op_ready_reg <= 1'b0;
          clear_reg    <= 1'b0;
          force_en_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_busy           = busy_reg;
  assign bus.o_done           = done_reg;
  assign bus.o_op_ready       = op_ready_reg;
  assign bus.o_pe_reg_clear   = clear_reg;
  assign bus.o_pe_pipeline_en = force_en_reg | op_fire;
  assign bus.o_pe_a           = op_fire ? bus.i_op_a : '0;
  assign bus.o_pe_b           = op_fire ? bus.i_op_b : '0;
  assign bus.o_res_valid      = res_valid_reg;
  assign bus.o_res_data       = res_data_reg;

`ifdef SA_PE_SEQ_PERF_CNT_EN
  logic [31:0] busy_cycles_reg;
  logic [31:0] stall_cycles_reg;

  // Saturating busy/stall counters, restarted by each accepted job.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy_cycles_reg  <= '0;
      stall_cycles_reg <= '0;
    end else if (state_reg == IDLE && bus.i_start) begin
      busy_cycles_reg  <= '0;
      stall_cycles_reg <= '0;
    end else begin
      if (busy_reg && busy_cycles_reg != '1)
        busy_cycles_reg <= busy_cycles_reg + 32'd1;
      if (state_reg == FEED && !bus.i_op_valid && stall_cycles_reg != '1)
        stall_cycles_reg <= stall_cycles_reg + 32'd1;
    end
  end

  assign bus.o_busy_cycles  = busy_cycles_reg;
  assign bus.o_stall_cycles = stall_cycles_reg;
`endif

endmodule

// File: tb/tb_sa_pe_sequencer.sv
// Directed bench for sa_pe_sequencer with a small behavioural PE
// (integer-valued FP16 products, FP32 accumulator, PE_LAT pipeline).
module tb_sa_pe_sequencer;
  localparam int IA_W   = 16;
  localparam int IB_W   = 16;
  localparam int OC_W   = 32;
  localparam int K_W    = 16;
  localparam int PE_LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] tab_a [4];
  logic [15:0] tab_b [4];

  always #5 clk = ~clk;

  sa_pe_sequencer_if #(.IA_W(IA_W), .IB_W(IB_W), .OC_W(OC_W), .K_W(K_W)) bus ();

  sa_pe_sequencer #(
    .IA_W(IA_W), .IB_W(IB_W), .OC_W(OC_W), .K_W(K_W), .PE_LAT(PE_LAT)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // FP16 operands used here are small integers
  function automatic int fp16_to_int(input logic [15:0] h);
    int e;
    int m;
    if (h[14:0] == 15'd0) return 0;
    e = int'(h[14:10]);
    m = 1024 + int'(h[9:0]);
    if (e >= 25) return m << (e - 25);
    return m >> (25 - e);
  endfunction

  function automatic logic [31:0] int_to_fp32(input int v);
    int e;
    logic [31:0] mant;
    logic [7:0] ex;
    if (v <= 0) return 32'h0;
    e = 0;
    for (int i = 0; i < 24; i++) if (v >= (1 << i)) e = i;
    mant = (32'(v) << (23 - e)) & 32'h007F_FFFF;
    ex = 8'(127 + e);
    return {1'b0, ex, mant[22:0]};
  endfunction

  // behavioural PE: clear and products travel PE_LAT enabled cycles to the accumulator
  logic [PE_LAT-1:0] pe_clr_pipe = '0;
  int pe_prod_pipe [PE_LAT] = '{default: 0};
  int pe_acc = 0;

  always @(posedge clk) begin
    if (bus.o_pe_pipeline_en) begin
      pe_acc <= pe_clr_pipe[PE_LAT-1] ? 0 : pe_acc + pe_prod_pipe[PE_LAT-1];
      for (int i = PE_LAT - 1; i > 0; i--) begin
        pe_clr_pipe[i]  <= pe_clr_pipe[i-1];
        pe_prod_pipe[i] <= pe_prod_pipe[i-1];
      end
      pe_clr_pipe[0]  <= bus.o_pe_reg_clear;
      pe_prod_pipe[0] <= fp16_to_int(bus.o_pe_a) * fp16_to_int(bus.o_pe_b);
    end
  end

  assign bus.i_pe_c = int_to_fp32(pe_acc);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},   64'(bus.o_busy), 64'd0);
    check({tag, "_done"},   64'(bus.o_done), 64'd0);
    check({tag, "_ready"},  64'(bus.o_op_ready), 64'd0);
    check({tag, "_clear"},  64'(bus.o_pe_reg_clear), 64'd0);
    check({tag, "_pe_en"},  64'(bus.o_pe_pipeline_en), 64'd0);
    check({tag, "_pe_ab"},  64'({bus.o_pe_a, bus.o_pe_b}), 64'd0);
    check({tag, "_rvalid"}, 64'(bus.o_res_valid), 64'd0);
    check({tag, "_rdata"},  64'(bus.o_res_data), 64'd0);
  endtask

  // One complete job: operands from tab_a/tab_b, optional 'gap' idle cycles
  // after each handshake, result sink held off for 'hold' cycles.
  task automatic run_job(input string name, input int k, input int gap, input int hold,
                         input bit poke_start, input logic [31:0] exp_res, input int exp_lat);
    int n, idx, gap_left, hs_cnt, lat;
    bit pend, got;
    logic [31:0] data;
    n = 0; idx = 0; gap_left = 0; hs_cnt = 0; lat = 0; got = 0; data = '0;
    @(negedge clk);
    bus.i_start     = 1'b1;
    bus.i_k_len     = K_W'(k);
    bus.i_res_ready = 1'b0;
    bus.i_op_valid  = (k > 0);
    bus.i_op_a      = tab_a[0];
    bus.i_op_b      = tab_b[0];
    pend = bus.i_op_valid && bus.o_op_ready;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      bus.i_start = 1'b0;
      if (pend) begin
        idx++;
        hs_cnt++;
        gap_left = gap;
      end
      if (bus.o_res_valid) begin
        got  = 1'b1;
        lat  = n;
        data = bus.o_res_data;
      end
      if (gap_left > 0 && bus.o_op_ready) begin
        bus.i_op_valid = 1'b0;
        bus.i_op_a = '0;
        bus.i_op_b = '0;
        gap_left--;
        #1;
        check({name, "_gap_pe_en"}, 64'(bus.o_pe_pipeline_en), 64'd0);
      end else if (idx < k) begin
        bus.i_op_valid = 1'b1;
        bus.i_op_a = tab_a[idx];
        bus.i_op_b = tab_b[idx];
      end else begin
        bus.i_op_valid = 1'b0;
        bus.i_op_a = '0;
        bus.i_op_b = '0;
      end
      pend = bus.i_op_valid && bus.o_op_ready;
    end
    check({name, "_no_timeout"}, 64'(got), 64'd1);
    if (got) begin
      check({name, "_latency"},  64'(lat), 64'(exp_lat));
      check({name, "_result"},   64'(data), 64'(exp_res));
      check({name, "_handshakes"}, 64'(hs_cnt), 64'(k));
      check({name, "_busy"},     64'(bus.o_busy), 64'd1);
      for (int i = 0; i < hold; i++) begin
        if (poke_start) bus.i_start = (i % 2 == 0);
        @(negedge clk);
        check({name, "_hold_valid"}, 64'(bus.o_res_valid), 64'd1);
        check({name, "_hold_data"},  64'(bus.o_res_data), 64'(data));
        check({name, "_hold_done"},  64'(bus.o_done), 64'd0);
      end
      bus.i_start     = 1'b0;
      bus.i_res_ready = 1'b1;
      @(negedge clk);
      bus.i_res_ready = 1'b0;
      check({name, "_valid_drop"}, 64'(bus.o_res_valid), 64'd0);
      check({name, "_done_pulse"}, 64'(bus.o_done), 64'd1);
      check({name, "_idle_busy"},  64'(bus.o_busy), 64'd0);
      @(negedge clk);
      check({name, "_done_single"}, 64'(bus.o_done), 64'd0);
      check({name, "_no_requeue"},  64'(bus.o_busy), 64'd0);
    end
    $display("job %s k=%0d lat=%0d result=0x%08h", name, k, lat, data);
  endtask

  initial begin
    bus.i_start     = 1'b0;
    bus.i_k_len     = '0;
    bus.i_op_valid  = 1'b0;
    bus.i_op_a      = '0;
    bus.i_op_b      = '0;
    bus.i_res_ready = 1'b0;
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: K=1, 1.0*2.0
    tab_a[0] = 16'h3C00; tab_b[0] = 16'h4000;
    run_job("k1", 1, 0, 0, 1'b0, 32'h4000_0000, 1 + PE_LAT + 3);

    // 2: K=2 back-to-back, 2*1 + 1*1 = 3
    tab_a[0] = 16'h4000; tab_b[0] = 16'h3C00;
    tab_a[1] = 16'h3C00; tab_b[1] = 16'h3C00;
    run_job("k2", 2, 0, 0, 1'b0, 32'h4040_0000, 2 + PE_LAT + 3);

    // 3: K=3 with 2-cycle valid gaps, sum 3, four stall cycles
    for (int i = 0; i < 3; i++) begin
      tab_a[i] = 16'h3C00; tab_b[i] = 16'h3C00;
    end
    run_job("k3gap", 3, 2, 0, 1'b0, 32'h4040_0000, 3 + PE_LAT + 3 + 4);
`ifdef SA_PE_SEQ_PERF_CNT_EN
    check("k3gap_stalls", 64'(bus.o_stall_cycles), 64'd4);
`endif

    // 4: result backpressure with start pulses during the job, 2*2 + 1*2 = 6
    tab_a[0] = 16'h4000; tab_b[0] = 16'h4000;
    tab_a[1] = 16'h3C00; tab_b[1] = 16'h4000;
    run_job("hold", 2, 0, 6, 1'b1, 32'h40C0_0000, 2 + PE_LAT + 3);

    // 5: K=0 returns the cleared accumulator
    tab_a[0] = 16'h4400; tab_b[0] = 16'h4400;
    run_job("k0", 0, 0, 0, 1'b0, 32'h0000_0000, 0 + PE_LAT + 3);

    // 6: reset in the middle of FEED, then a fresh job 3*4 = 12
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_k_len = 16'd3;
    bus.i_op_valid = 1'b1; bus.i_op_a = 16'h4400; bus.i_op_b = 16'h4400;
    @(negedge clk);
    bus.i_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midjob_busy",  64'(bus.o_busy), 64'd1);
    check("midjob_ready", 64'(bus.o_op_ready), 64'd1);
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    bus.i_op_valid = 1'b0; bus.i_op_a = '0; bus.i_op_b = '0;
    tab_a[0] = 16'h4200; tab_b[0] = 16'h4400;
    run_job("after_rst", 1, 0, 0, 1'b0, 32'h4140_0000, 1 + PE_LAT + 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
